fc_tile_sequencer: RTL
======================

// Module: fc_tile_sequencer
// PURPOSE
// - Sequences one fully-connected layer through the systolic array and the FC accumulator.
// - Splits the input vector into tiles of ARRAY_DIM features; per tile: weight load, psum feed, pipeline drain.
// - Publishes layer geometry (out_node_num_o, tile_num_o) to the accumulator.
// - After the last tile, waits for the accumulator's last beat, then reports done.
// PARAMETERS
// - ARRAY_DIM  8    systolic rows = input features consumed per tile
// - MAX_TILES  16   maximum tiles per layer (tile_num_o is 4 bits: 1..16, 16 encoded as 0)
// - IN_W       10   width of in_len_i
// - DRAIN_CYC  9    cycles idle after the last feed beat for psums to leave the array (ARRAY_DIM+1)
// PORTS
// - clk             in   1     clock
// - rst_n           in   1     asynchronous active-low reset
// - start_i         in   1     start layer; sampled only in IDLE
// - in_len_i        in   IN_W  input feature count, 1..ARRAY_DIM*MAX_TILES
// - out_len_i       in   7     output node count, 1..127
// - busy_o          out  1     high from accepted start until done_o/err_o
// - done_o          out  1     1-cycle pulse: layer complete
// - err_o           out  1     1-cycle pulse: bad config or timeout
// - out_node_num_o  out  7     latched out_len_i; stable while busy_o
// - tile_num_o      out  4     latched tile count; stable while busy_o
// - wload_req_o     out  1     weight-load request for tile_idx_o; held until ack
// - wload_ack_i     in   1     weight load finished
// - feed_valid_o    out  1     input-feed beat valid
// - feed_ready_i    in   1     beat accepted when valid && ready
// - tile_idx_o      out  4     current tile, 0-based
// - node_idx_o      out  7     current output-node beat within tile, 0-based
// - acc_last_i      in   1     accumulator last-output pulse
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters 0.
// - Config latched on start; tiles = ceil(in_len_i/ARRAY_DIM).
// - IDLE: start_i && in_len_i in range && out_len_i!=0 -> LOAD_W (busy_o=1 next cycle);
//   otherwise with start_i -> err_o pulse, remain IDLE.
// - LOAD_W: wload_req_o=1; on wload_ack_i -> FEED; node_idx=0.
// - FEED: feed_valid_o=1; each handshake increments node_idx; handshake at node_idx==out_len-1 -> DRAIN.
//   While feed_ready_i=0: feed_valid_o, tile_idx_o and node_idx_o hold.
// - DRAIN: DRAIN_CYC-cycle counter.
//   At expiry: if tile_idx==tiles-1 -> WAIT_ACC; else tile_idx+1 -> LOAD_W.
// - WAIT_ACC: acc_last_i -> DONE. acc_last_i in any other state is ignored.
// - DONE: done_o=1 one cycle, busy_o=0, -> IDLE. New start_i accepted the cycle after DONE.
// - start_i while busy: ignored, no error.
// - Reset mid-layer: immediate return to IDLE, outputs cleared, no done/err pulse.
// - Single tile (in_len_i<=ARRAY_DIM): LOAD_W, FEED, DRAIN, WAIT_ACC.
// - out_len_i==1: FEED lasts exactly one handshake.
// - Latency, no stalls: start -> done = tiles*(2+out_len+DRAIN_CYC) + WAIT_ACC + 1.
//   The 2 is one LOAD_W cycle, assuming ack in the same cycle, plus one FEED entry cycle.
// CONFIGURATION
// - FC_SEQ_TIMEOUT_EN defined: 16-bit watchdog runs in WAIT_ACC and LOAD_W, cleared on state entry.
//   If it reaches 16'hFFFF: err_o pulse, busy_o=0, -> IDLE.
// - FC_SEQ_TIMEOUT_EN undefined: no watchdog; waits indefinitely; err_o only for bad config.
// STRUCTURE
// - fc_pkg: state enum fc_seq_state_e {IDLE,LOAD_W,FEED,DRAIN,WAIT_ACC,DONE}, ARRAY_DIM/MAX_TILES
//   localparams, tile_cnt_t/node_cnt_t typedefs.
// - Sub-module fc_seq_watchdog: counter with clear/enable/expire; instantiated only under FC_SEQ_TIMEOUT_EN.
// TESTING
// - in_len=20, out_len=10, always ready/ack:
//   tile_num_o=3; 3 wload_req; 30 feed beats with tile 0..2 and node 0..9; acc_last -> one done_o.
// - in_len=8, out_len=1: single tile, single feed beat, DRAIN 9 cycles, WAIT_ACC, done_o.
// - Random feed_ready_i stalls at 50%: beat indices hold during stall, no beat lost or duplicated.
// - in_len=0, then out_len=0, then in_len=129: err_o pulse each time, busy_o stays 0.
// - rst_n low during FEED of tile 1: next cycle all outputs 0; fresh start_i runs the full layer from tile 0.
// - FC_SEQ_TIMEOUT_EN: acc_last_i withheld -> err_o after 65535 WAIT_ACC cycles, then IDLE.
//   Without the macro: busy_o stays high.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and default geometry for the FC tile sequencer.
// Optional watchdog is enabled with FC_SEQ_TIMEOUT_EN.
package fc_pkg;

  localparam int FC_ARRAY_DIM = 8;
  localparam int FC_MAX_TILES = 16;
  localparam int FC_IN_W      = 10;
  localparam int FC_DRAIN_CYC = FC_ARRAY_DIM + 1;
  localparam int FC_WD_W      = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    FEED     = 3'd2,
    DRAIN    = 3'd3,
    WAIT_ACC = 3'd4,
    DONE     = 3'd5
  } fc_seq_state_e;

  typedef logic [3:0] tile_cnt_t;
  typedef logic [6:0] node_cnt_t;

endpackage

// File: rtl/fc_tile_sequencer_if.sv
// Array / accumulator side of the FC tile sequencer: weight load, psum feed,
// layer geometry and the accumulator's last-beat pulse.
interface fc_tile_sequencer_if;
  import fc_pkg::*;

  node_cnt_t out_node_num_o;
  tile_cnt_t tile_num_o;
  logic      wload_req_o;
  logic      wload_ack_i;
  logic      feed_valid_o;
  logic      feed_ready_i;
  tile_cnt_t tile_idx_o;
  node_cnt_t node_idx_o;
  logic      acc_last_i;

  modport master (
    output out_node_num_o, tile_num_o, wload_req_o, feed_valid_o, tile_idx_o, node_idx_o,
    input  wload_ack_i, feed_ready_i, acc_last_i
  );

  modport slave (
    input  out_node_num_o, tile_num_o, wload_req_o, feed_valid_o, tile_idx_o, node_idx_o,
    output wload_ack_i, feed_ready_i, acc_last_i
  );

endinterface

// File: rtl/fc_seq_watchdog.sv
// Saturating watchdog counter: clear wins over enable, expire at all-ones.
// Instantiated by fc_tile_sequencer only when FC_SEQ_TIMEOUT_EN is defined.
module fc_seq_watchdog #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == {W{1'b1}});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (en_i && !expire_o) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fc_tile_sequencer.sv
// Walks one FC layer tile by tile: weight load, psum feed, drain, then waits
// for the accumulator. FC_SEQ_TIMEOUT_EN adds a watchdog on LOAD_W/WAIT_ACC.
module fc_tile_sequencer
  import fc_pkg::*;
#(
  parameter int ARRAY_DIM = FC_ARRAY_DIM,
  parameter int MAX_TILES = FC_MAX_TILES,
  parameter int IN_W      = FC_IN_W,
  parameter int DRAIN_CYC = FC_DRAIN_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [IN_W-1:0]     in_len_i,
  input  node_cnt_t           out_len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  fc_tile_sequencer_if.master acc_if
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [IN_W:0] MAX_LEN = (IN_W+1)'(ARRAY_DIM * MAX_TILES);
  localparam logic [IN_W:0] DIM_W   = (IN_W+1)'(ARRAY_DIM);

  fc_seq_state_e  state_q, state_d;
  tile_cnt_t      tile_idx_q, tile_idx_d;
  node_cnt_t      node_idx_q, node_idx_d;
  node_cnt_t      out_len_q, out_len_d;
  tile_cnt_t      tile_num_q, tile_num_d;
  tile_cnt_t      tiles_m1_q, tiles_m1_d;
  logic [DW-1:0]  drain_cnt_q, drain_cnt_d;
  logic           feed_valid_q, feed_valid_d;
  logic           err_q, err_d;

  logic           cfg_ok;
  logic [IN_W:0]  tiles_w;
  tile_cnt_t      tiles_calc;
  logic           feed_hs;
  logic           wd_expire;

  // 16 tiles wraps to 4'd0 in tile_num_o; tiles-1 still lands on 15.
  assign tiles_w    = ({1'b0, in_len_i} + DIM_W - (IN_W+1)'(1)) / DIM_W;
  assign tiles_calc = tile_cnt_t'(tiles_w);
  assign cfg_ok     = (in_len_i != '0) && ({1'b0, in_len_i} <= MAX_LEN) && (out_len_i != '0);
  assign feed_hs    = feed_valid_q && acc_if.feed_ready_i;

`ifdef FC_SEQ_TIMEOUT_EN
  logic wd_clr, wd_en;

  assign wd_en  = (state_q == LOAD_W) || (state_q == WAIT_ACC);
  assign wd_clr = (state_d != state_q);

  fc_seq_watchdog #(.W(FC_WD_W)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    tile_idx_d   = tile_idx_q;
    node_idx_d   = node_idx_q;
    out_len_d    = out_len_q;
    tile_num_d   = tile_num_q;
    tiles_m1_d   = tiles_m1_q;
    drain_cnt_d  = drain_cnt_q;
    feed_valid_d = feed_valid_q;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            state_d    = LOAD_W;
            out_len_d  = out_len_i;
            tile_num_d = tiles_calc;
            tiles_m1_d = tiles_calc - tile_cnt_t'(1);
            tile_idx_d = '0;
            node_idx_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD_W: begin
        if (acc_if.wload_ack_i) begin
          state_d    = FEED;
          node_idx_d = '0;
        end
      end

      // feed_valid is registered, so the first FEED cycle is a bubble that
      // separates the weight-load ack from the first psum beat.
      FEED: begin
        feed_valid_d = 1'b1;
        if (feed_hs) begin
          if (node_idx_q == out_len_q - node_cnt_t'(1)) begin
            state_d      = DRAIN;
            feed_valid_d = 1'b0;
            drain_cnt_d  = '0;
          end else begin
            node_idx_d = node_idx_q + node_cnt_t'(1);
          end
        end
      end

      DRAIN: begin
        drain_cnt_d = drain_cnt_q + DW'(1);
        if (drain_cnt_q == DW'(DRAIN_CYC - 1)) begin
          if (tile_idx_q == tiles_m1_q) begin
            state_d = WAIT_ACC;
          end else begin
            state_d    = LOAD_W;
            tile_idx_d = tile_idx_q + tile_cnt_t'(1);
          end
        end
      end

      WAIT_ACC: begin
        if (acc_if.acc_last_i) state_d = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wd_expire && ((state_q == LOAD_W) || (state_q == WAIT_ACC))) begin
      state_d      = IDLE;
      err_d        = 1'b1;
      feed_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tile_idx_q   <= '0;
      node_idx_q   <= '0;
      out_len_q    <= '0;
      tile_num_q   <= '0;
      tiles_m1_q   <= '0;
      drain_cnt_q  <= '0;
      feed_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_idx_q   <= tile_idx_d;
      node_idx_q   <= node_idx_d;
      out_len_q    <= out_len_d;
      tile_num_q   <= tile_num_d;
      tiles_m1_q   <= tiles_m1_d;
      drain_cnt_q  <= drain_cnt_d;
      feed_valid_q <= feed_valid_d;
      err_q        <= err_d;
    end
  end

  assign busy_o = (state_q == LOAD_W) || (state_q == FEED) ||
                  (state_q == DRAIN)  || (state_q == WAIT_ACC);
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;

  assign acc_if.wload_req_o    = (state_q == LOAD_W);
  assign acc_if.feed_valid_o   = feed_valid_q;
  assign acc_if.tile_idx_o     = tile_idx_q;
  assign acc_if.node_idx_o     = node_idx_q;
  assign acc_if.out_node_num_o = out_len_q;
  assign acc_if.tile_num_o     = tile_num_q;

endmodule
